ffs_scatter_m: RTL and testbench
================================

Name: ffs_scatter_m

Overview:
- Inverse companion of the find-first-set encoder: converts a stream of bit indices back into a bit-vector mask.
- Accepts index beats over a valid/ready handshake and ORs the decoded one-hot of each beat into an accumulator.
- On the beat flagged last, presents the completed mask, a set-bit count and an error flag on an output handshake.
- Sits downstream of index-producing logic (e.g. iterated FFS drains, free-slot lists) to rebuild occupancy/request vectors.

Parameters:
- INPUT_WIDTH, 8, mask width in bits; any value >= 1, not required to be a power of two.
- IDX_WIDTH, derived localparam = clog2(max(INPUT_WIDTH,2)), index width; matches the FFS encoder output width.
- CNT_WIDTH, derived localparam = clog2(INPUT_WIDTH+1) (minimum 1), width of the set-bit count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  index beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_idx  input  IDX_WIDTH  bit index to set.
- in_last  input  1  final beat of the frame.
- out_valid  output  1  completed mask available.
- out_ready  input  1  consumer takes the mask.
- out_mask  output  INPUT_WIDTH  accumulated mask.
- out_cnt  output  CNT_WIDTH  number of distinct bits set in out_mask.
- out_err  output  1  frame contained an out-of-range index (and, optionally, a duplicate).

Behaviour:
- Reset is synchronous and active-high; one clock.
- Reset values: state ACCUM, accumulator 0, count 0, err 0, out_valid 0, out_mask 0, out_cnt 0, out_err 0.
- Reset mid-frame or while holding output discards all accumulated data; no partial frame is emitted.
- Two states:
  - ACCUM: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- A beat is accepted when in_valid && in_ready; dec = one-hot(in_idx).
- Range rule: if in_idx >= INPUT_WIDTH, dec = 0 and the frame error is set. Indices at or above INPUT_WIDTH exist only when INPUT_WIDTH is not a power of two.
- Count rule: count increments by 1 only when dec is nonzero and its bit is not already set in the accumulator. The count never exceeds INPUT_WIDTH and never wraps.
- Accepted beat with in_last = 0: accumulator |= dec, count and err update; stay in ACCUM.
- Accepted beat with in_last = 1:
  - out_mask, out_cnt and out_err load the final values, including this beat.
  - The accumulator, count and err clear.
  - State moves to HOLD; out_valid rises on the next cycle (latency 1 from the last beat).
- A single-beat frame (in_last on the first beat) is legal.
- HOLD: outputs stay stable while out_valid && !out_ready. On out_ready, return to ACCUM next cycle; out_mask, out_cnt and out_err keep their last values.
- Throughput: at most one frame per (beats + 1) cycles; no input is accepted during HOLD.
- in_idx and in_last are ignored when in_valid = 0.
- A frame with all indices out of range yields out_mask = 0, out_cnt = 0, out_err = 1.

Optional Feature:
- Macro: FFS_SCATTER_DUP_ERR_EN.
- Defined: an accepted in-range beat whose bit is already set in the accumulator also sets the frame error. The error becomes visible on out_err for that frame.
- Undefined: duplicates merge silently; out_err reflects out-of-range indices only.
- Mask and count behaviour are identical in both cases.

Decomposition:
- Shared package ffs_pkg:
  - function get_depth(w) = clog2(max(w,2)), also used by the FFS encoder.
  - ACCUM/HOLD state encoding.
- One natural sub-module: ffs_dec_m (combinational index -> one-hot with range-valid output), parameterised by INPUT_WIDTH.
- The top level holds the FSM, accumulator, counter and output registers.

Test Plan:
- INPUT_WIDTH=8: beats 3, 0, 7(last), out_ready held 1 -> out_valid one cycle after the last beat; out_mask=0x89, out_cnt=3, out_err=0.
- Single beat idx 5 with last, out_ready=0 for 4 cycles -> out_mask=0x20 stable and in_ready=0 throughout; after out_ready, in_ready=1 the next cycle.
- Beats 2, 2, 4(last):
  - out_mask=0x14, out_cnt=2 in both builds.
  - out_err=1 with FFS_SCATTER_DUP_ERR_EN defined.
  - out_err=0 without it.
- INPUT_WIDTH=6: beats 1, 6, 7(last) -> out_mask=0x02, out_cnt=1, out_err=1.
- rst asserted after beats 0, 1 of a frame, then frame 4(last) -> out_mask=0x10, out_cnt=1; no earlier frame is emitted.
- Back-to-back frames {0(last)} and {1(last)} with in_valid held high and out_ready=1 -> masks 0x01 then 0x02; the second frame's beat is accepted only after HOLD exits.

Source files
------------

// File: rtl/ffs_pkg.sv
// Shared definitions for the find-first-set encoder family: index width helper and
// the scatter FSM state encoding.
package ffs_pkg;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Index width for a w-bit vector; a 1-bit vector still gets a 1-bit index.
  function automatic int get_depth(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ffs_dec_m.sv
// Combinational index to one-hot decoder. Indices at or beyond INPUT_WIDTH decode
// to zero and report out-of-range.
module ffs_dec_m
  import ffs_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  localparam int IDX_WIDTH = get_depth(INPUT_WIDTH)
) (
  input  logic [IDX_WIDTH-1:0]   i_idx,
  output logic [INPUT_WIDTH-1:0] o_dec,
  output logic                   o_in_range
);

  always_comb begin
    o_dec = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      o_dec[i] = (i_idx == i[IDX_WIDTH-1:0]);
    end
  end

  // Exactly one bit is set for a legal index, none otherwise.
  assign o_in_range = |o_dec;

endmodule

// File: rtl/ffs_scatter_m.sv
// Index-stream to bit-mask scatter: ORs decoded indices into a mask until the last beat.
// Optional macro FFS_SCATTER_DUP_ERR_EN also flags duplicate indices as frame errors.
module ffs_scatter_m
  import ffs_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  localparam int IDX_WIDTH = get_depth(INPUT_WIDTH),
  localparam int CNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_WIDTH-1:0]   in_idx,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] out_mask,
  output logic [CNT_WIDTH-1:0]   out_cnt,
  output logic                   out_err
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [INPUT_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_err;
  logic [INPUT_WIDTH-1:0] r_out_mask;
  logic [CNT_WIDTH-1:0]   r_out_cnt;
  logic                   r_out_err;

  logic [INPUT_WIDTH-1:0] w_dec;
  logic                   w_in_range;
  logic                   w_fire;
  logic                   w_is_new;
  logic                   w_dup_err;
  logic [INPUT_WIDTH-1:0] w_acc_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic                   w_err_nxt;

  ffs_dec_m #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_dec (
    .i_idx      (in_idx),
    .o_dec      (w_dec),
    .o_in_range (w_in_range)
  );

  assign w_fire    = in_valid && in_ready;
  // Count only bits that are newly set; the mask width bounds the count, so it cannot wrap.
  assign w_is_new  = |(w_dec & ~r_acc);
  assign w_acc_nxt = r_acc | w_dec;
  assign w_cnt_nxt = r_cnt + CNT_WIDTH'(w_is_new);

`ifdef FFS_SCATTER_DUP_ERR_EN
  assign w_dup_err = |(w_dec & r_acc);
`else
  assign w_dup_err = 1'b0;
`endif

  assign w_err_nxt = r_err | ~w_in_range | w_dup_err;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (w_fire && in_last) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_out_mask <= '0;
      r_out_cnt  <= '0;
      r_out_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        if (in_last) begin
          // Publish the completed frame and start the next one from a clean accumulator.
          r_out_mask <= w_acc_nxt;
          r_out_cnt  <= w_cnt_nxt;
          r_out_err  <= w_err_nxt;
          r_acc      <= '0;
          r_cnt      <= '0;
          r_err      <= 1'b0;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
          r_err <= w_err_nxt;
        end
      end
    end
  end

  assign out_mask = r_out_mask;
  assign out_cnt  = r_out_cnt;
  assign out_err  = r_out_err;

endmodule

// File: tb/tb_ffs_scatter_m.sv
// Directed bench for ffs_scatter_m: an 8-bit instance driven from a frame table plus
// hand sequences, and a 6-bit instance for out-of-range indices.
module tb_ffs_scatter_m;

`ifdef FFS_SCATTER_DUP_ERR_EN
  localparam logic DUPE = 1'b1;
`else
  localparam logic DUPE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, in_last8, out_valid8, out_ready8, out_err8;
  logic [2:0] in_idx8;
  logic [7:0] out_mask8;
  logic [3:0] out_cnt8;

  logic       in_valid6, in_ready6, in_last6, out_valid6, out_ready6, out_err6;
  logic [2:0] in_idx6;
  logic [5:0] out_mask6;
  logic [2:0] out_cnt6;

  ffs_scatter_m #(.INPUT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_idx(in_idx8), .in_last(in_last8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_mask(out_mask8), .out_cnt(out_cnt8), .out_err(out_err8)
  );

  ffs_scatter_m #(.INPUT_WIDTH(6)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_idx(in_idx6), .in_last(in_last6),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .out_mask(out_mask6), .out_cnt(out_cnt6), .out_err(out_err6)
  );

  typedef struct {
    int         n;
    int         idx[8];
    logic [7:0] mask;
    int         cnt;
    logic       err;
  } vec8_t;

  vec8_t tv8[6];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run8(input int k);
    out_ready8 = 1'b1;
    for (int b = 0; b < tv8[k].n; b++) begin
      @(negedge clk);
      in_valid8 = 1'b1;
      in_idx8   = 3'(tv8[k].idx[b]);
      in_last8  = (b == tv8[k].n - 1);
      chk($sformatf("v%0d in_ready b%0d", k, b), int'(in_ready8), 1);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      in_last8  = 1'b0;
      if (b < tv8[k].n - 1) chk($sformatf("v%0d early out_valid", k), int'(out_valid8), 0);
    end
    chk($sformatf("v%0d out_valid", k), int'(out_valid8), 1);
    chk($sformatf("v%0d out_mask", k), int'(out_mask8), int'(tv8[k].mask));
    chk($sformatf("v%0d out_cnt", k), int'(out_cnt8), tv8[k].cnt);
    chk($sformatf("v%0d out_err", k), int'(out_err8), int'(tv8[k].err));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d exit out_valid", k), int'(out_valid8), 0);
    chk($sformatf("v%0d exit in_ready", k), int'(in_ready8), 1);
  endtask

  task automatic beat8(input int idx, input logic last);
    @(negedge clk);
    in_valid8 = 1'b1;
    in_idx8   = 3'(idx);
    in_last8  = last;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    in_last8  = 1'b0;
  endtask

  task automatic beat6(input int idx, input logic last);
    @(negedge clk);
    in_valid6 = 1'b1;
    in_idx6   = 3'(idx);
    in_last6  = last;
    @(posedge clk);
    #1;
    in_valid6 = 1'b0;
    in_last6  = 1'b0;
  endtask

  initial begin
    tv8[0] = '{3, '{3, 0, 7, 0, 0, 0, 0, 0}, 8'h89, 3, 1'b0};
    tv8[1] = '{3, '{2, 2, 4, 0, 0, 0, 0, 0}, 8'h14, 2, DUPE};
    tv8[2] = '{1, '{5, 0, 0, 0, 0, 0, 0, 0}, 8'h20, 1, 1'b0};
    tv8[3] = '{4, '{7, 7, 7, 7, 0, 0, 0, 0}, 8'h80, 1, DUPE};
    tv8[4] = '{4, '{0, 1, 2, 3, 0, 0, 0, 0}, 8'h0F, 4, 1'b0};
    tv8[5] = '{8, '{7, 6, 5, 4, 3, 2, 1, 0}, 8'hFF, 8, 1'b0};

    rst = 1'b1;
    in_valid8 = 1'b0; in_idx8 = 3'd0; in_last8 = 1'b0; out_ready8 = 1'b1;
    in_valid6 = 1'b0; in_idx6 = 3'd0; in_last6 = 1'b0; out_ready6 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst in_ready", int'(in_ready8), 1);
    chk("rst out_valid", int'(out_valid8), 0);
    chk("rst out_mask", int'(out_mask8), 0);
    chk("rst out_cnt", int'(out_cnt8), 0);
    chk("rst out_err", int'(out_err8), 0);

    for (int k = 0; k < 6; k++) run8(k);

    // Stall in HOLD: outputs stable, no beat accepted even with in_valid high.
    out_ready8 = 1'b0;
    beat8(5, 1'b1);
    @(negedge clk);
    in_valid8 = 1'b1; in_idx8 = 3'd1; in_last8 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("stall out_valid", int'(out_valid8), 1);
      chk("stall in_ready", int'(in_ready8), 0);
      chk("stall out_mask", int'(out_mask8), 'h20);
      chk("stall out_cnt", int'(out_cnt8), 1);
      @(negedge clk);
    end
    in_valid8 = 1'b0; in_last8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    chk("stall exit in_ready", int'(in_ready8), 1);
    chk("stall exit out_valid", int'(out_valid8), 0);
    chk("stall keep out_mask", int'(out_mask8), 'h20);

    // Out-of-range indices on the 6-bit instance.
    beat6(1, 1'b0);
    beat6(6, 1'b0);
    chk("w6 early out_valid", int'(out_valid6), 0);
    beat6(7, 1'b1);
    chk("w6 out_valid", int'(out_valid6), 1);
    chk("w6 out_mask", int'(out_mask6), 'h02);
    chk("w6 out_cnt", int'(out_cnt6), 1);
    chk("w6 out_err", int'(out_err6), 1);
    beat6(6, 1'b1);
    @(posedge clk);
    #1;
    beat6(7, 1'b1);
    chk("w6 allbad out_mask", int'(out_mask6), 0);
    chk("w6 allbad out_cnt", int'(out_cnt6), 0);
    chk("w6 allbad out_err", int'(out_err6), 1);
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame.
    beat8(0, 1'b0);
    beat8(1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst out_valid", int'(out_valid8), 0);
    chk("midrst out_mask", int'(out_mask8), 0);
    beat8(4, 1'b1);
    chk("midrst out_valid", int'(out_valid8), 1);
    chk("midrst out_mask", int'(out_mask8), 'h10);
    chk("midrst out_cnt", int'(out_cnt8), 1);
    chk("midrst out_err", int'(out_err8), 0);
    @(posedge clk);
    #1;

    // Reset while holding output drops the held frame.
    out_ready8 = 1'b0;
    beat8(3, 1'b1);
    chk("holdrst pre out_valid", int'(out_valid8), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready8 = 1'b1;
    chk("holdrst out_valid", int'(out_valid8), 0);
    chk("holdrst in_ready", int'(in_ready8), 1);
    chk("holdrst out_mask", int'(out_mask8), 0);

    // Back-to-back single-beat frames with in_valid held high.
    @(negedge clk);
    in_valid8 = 1'b1; in_idx8 = 3'd0; in_last8 = 1'b1;
    @(posedge clk);
    #1;
    in_idx8 = 3'd1;
    chk("b2b f0 out_valid", int'(out_valid8), 1);
    chk("b2b f0 out_mask", int'(out_mask8), 'h01);
    @(posedge clk);
    #1;
    chk("b2b gap out_valid", int'(out_valid8), 0);
    chk("b2b gap out_mask", int'(out_mask8), 'h01);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; in_last8 = 1'b0;
    chk("b2b f1 out_valid", int'(out_valid8), 1);
    chk("b2b f1 out_mask", int'(out_mask8), 'h02);
    chk("b2b f1 out_cnt", int'(out_cnt8), 1);
    @(posedge clk);
    #1;
    chk("b2b end out_valid", int'(out_valid8), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
